// File: rtl/ram_burst_master.sv
// ---------------------------------------------------------------------------
// ram_burst_master
//
// Burst initiator for a single-port synchronous RAM. A host request (start
// address, beat count minus one, direction) is turned into a sequence of RAM
// chip-select / write / output-enable cycles with an auto-incrementing
// address. Write beats are taken from a valid/ready stream; read beats are
// returned on a valid-only stream with a last-beat marker.
//
// Configuration macro:
//   RAM_BURST_WRAP_EN  defined   : bursts wrap from mem_depth-1 to 0; only
//                                  the start address is bounds checked.
//                      undefined : a burst whose last address would reach
//                                  mem_depth or beyond is rejected, and the
//                                  address never wraps.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   req_valid/ready    host request handshake (ready only while idle)
//   req_wr             1 = write burst, 0 = read burst
//   req_addr, req_len  burst start address and beat count minus one
//   wr_data/valid/ready write beat stream (ready only while writing)
//   rd_data/valid/last  read beat stream, registered, no backpressure
//   done, err          one-cycle completion pulse; err marks a rejected burst
//   ram_*              RAM control, address and data buses
// ---------------------------------------------------------------------------
module ram_burst_master #(
  parameter int data_width = 8,
  parameter int addr_size  = 4,
  parameter int mem_depth  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [addr_size-1:0]  req_addr,
  input  logic [addr_size-1:0]  req_len,
  input  logic [data_width-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  done,
  output logic                  err,
  output logic                  ram_cs,
  output logic                  ram_wr_rd,
  output logic                  ram_out_en,
  output logic [addr_size-1:0]  ram_address,
  output logic [data_width-1:0] ram_data_in,
  input  logic [data_width-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Depth expressed one bit wider than the address so that the comparison
  // against mem_depth == 2**addr_size is still meaningful.
  localparam logic [addr_size:0] DEPTH = (addr_size+1)'(mem_depth);

  state_t                  state_q, state_d;
  logic [addr_size-1:0]    addr_q, addr_d;
  logic [addr_size-1:0]    count_q, count_d;
  logic                    err_q, err_d;
  logic                    first_q, first_d;
  logic [data_width-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;

  logic                    req_bad;
  logic [addr_size-1:0]    addr_inc;

  // -------------------------------------------------------------------------
  // Bounds check and address increment
  // -------------------------------------------------------------------------
`ifdef RAM_BURST_WRAP_EN
  localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(mem_depth - 1);

  always_comb begin
    req_bad = ({1'b0, req_addr} >= DEPTH);
  end

  always_comb begin
    addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  end
`else
  logic [addr_size:0] end_addr;

  // Last address touched by the burst, computed without truncation.
  always_comb begin
    end_addr = {1'b0, req_addr} + {1'b0, req_len};
    req_bad  = (end_addr >= DEPTH);
  end

  // Accepted bursts never run past mem_depth-1, so a plain increment is safe.
  always_comb begin
    addr_inc = addr_q + 1'b1;
  end
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      first_q    <= first_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    first_d     = first_q;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    ram_cs      = 1'b0;
    ram_wr_rd   = 1'b0;
    ram_out_en  = 1'b0;
    ram_address = '0;
    ram_data_in = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          count_d = req_len;
          first_d = 1'b1;
          err_d   = req_bad;
          if (req_bad) begin
            state_d = ST_DONE;
          end else if (req_wr) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        wr_ready    = 1'b1;
        ram_cs      = wr_valid;
        ram_wr_rd   = 1'b1;
        ram_data_in = wr_data;
        ram_address = addr_q;
        if (wr_valid) begin
          addr_d  = addr_inc;
          count_d = count_q - 1'b1;
          if (count_q == '0) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_READ: begin
        ram_cs      = 1'b1;
        ram_address = addr_q;
        // The RAM has not produced data yet for the very first address.
        ram_out_en  = ~first_q;
        first_d     = 1'b0;
        if (count_q == '0) begin
          // Keep the last address on the bus so DRAIN re-reads it.
          state_d = ST_DRAIN;
        end else begin
          addr_d  = addr_inc;
          count_d = count_q - 1'b1;
        end
      end

      ST_DRAIN: begin
        // Enables the output for the final beat; the extra read is harmless.
        ram_cs      = 1'b1;
        ram_out_en  = 1'b1;
        ram_address = addr_q;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Read capture: data presented while the output is enabled is registered
  // and reported on the following cycle. The DRAIN cycle always carries the
  // final beat of a read burst.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_valid_d = ram_out_en;
    rd_last_d  = (state_q == ST_DRAIN);
    rd_data_d  = ram_out_en ? ram_data_out : rd_data_q;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

endmodule
